// File: rtl/nco_clkgen_pkg.sv
// Shared definitions for the multi-channel NCO clock-enable generator.
//   ACC_W_DEF / LOCK_CYCLES_DEF : default accumulator width and lock delay
//   ch_w()                      : channel-select width, max(1, clog2(n))
//   lock_state_t                : lock FSM encoding (SETTLING / LOCKED)
package nco_clkgen_pkg;

  localparam int ACC_W_DEF       = 32;
  localparam int LOCK_CYCLES_DEF = 16;

  // Width of the channel-select field; a single channel still gets one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    SETTLING = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/nco_channel.sv
// One phase-accumulator NCO channel.
//   clkin, reset      : clock and asynchronous active-high reset
//   en                : run enable; when low the accumulator and outputs sit at 0
//   wr                : accepted config write for this channel (one cycle)
//   wr_inc, wr_phase  : values captured into the shadow registers on wr
//   ce                : one-cycle pulse, registered carry of the accumulator add
//   clk               : registered MSB of (acc + phase), from the pre-update acc
//   pending           : shadow holds a config not yet applied
//   applied           : shadow is being copied to the live registers this cycle
module nco_channel
  import nco_clkgen_pkg::*;
#(
  parameter int               ACC_W     = ACC_W_DEF,
  parameter logic [ACC_W-1:0] RESET_INC = '0
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic [ACC_W-1:0] wr_phase,
  output logic             ce,
  output logic             clk,
  output logic             pending,
  output logic             applied
);

  // Upper half of the phase circle: (acc + phase) >= HALF is its MSB.
  localparam logic [ACC_W-1:0] HALF = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] shadow_inc;
  logic [ACC_W-1:0] shadow_phase;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_ph;
  logic             carry;
  logic             clk_next;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, inc};
    carry    = sum[ACC_W];
    acc_ph   = acc + phase;
    clk_next = (acc_ph >= HALF);
    // New settings only land at a wrap, or when the channel is idle
    // (disabled or zero increment) so no output edge can be torn.
    applied  = pending && ((en && carry) || !en || (inc == '0));
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      inc          <= RESET_INC;
      phase        <= '0;
      shadow_inc   <= '0;
      shadow_phase <= '0;
      pending      <= 1'b0;
      ce           <= 1'b0;
      clk          <= 1'b0;
    end else begin
      if (en) begin
        acc <= sum[ACC_W-1:0];
        ce  <= carry;
        clk <= clk_next;
      end else begin
        acc <= '0;
        ce  <= 1'b0;
        clk <= 1'b0;
      end

      if (applied) begin
        inc   <= shadow_inc;
        phase <= shadow_phase;
      end

      // A write is only accepted while pending is clear, so it can never
      // coincide with an apply; a write landing on a carry therefore waits
      // for the following wrap.
      if (wr) begin
        shadow_inc   <= wr_inc;
        shadow_phase <= wr_phase;
        pending      <= 1'b1;
      end else if (applied) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_nco_clkgen.sv
// Runtime-programmable multi-channel clock-enable generator.
//   clkin, reset     : clock and asynchronous active-high reset
//   ch_en            : per-channel run enable
//   cfg_valid/ready  : config write handshake
//   cfg_ch           : target channel (out-of-range writes are accepted and dropped)
//   cfg_inc/phase    : new increment / phase offset
//   ce_o, clk_o      : per-channel enable pulse and square wave
//   lock             : no config outstanding and LOCK_CYCLES quiet cycles elapsed
//   dbg_lock_state   : lock FSM state
//
// Handshake: a write transfers on any rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready is combinational on cfg_ch and is low
// only while the addressed channel still holds an unapplied config.
module multi_nco_clkgen
  import nco_clkgen_pkg::*;
#(
  parameter int                      NUM_CH      = 3,
  parameter int                      ACC_W       = ACC_W_DEF,
  parameter int                      LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_INC = '0
) (
  input  logic                        clkin,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_w(NUM_CH)-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]            cfg_inc,
  input  logic [ACC_W-1:0]            cfg_phase,
  output logic [NUM_CH-1:0]           ce_o,
  output logic [NUM_CH-1:0]           clk_o,
  output logic                        lock,
  output lock_state_t                 dbg_lock_state
);

  localparam int CH_W    = ch_w(NUM_CH);
  localparam int CH_SPAN = 1 << CH_W;
  localparam int CNT_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  applied;
  logic [NUM_CH-1:0]  wr;
  logic [CH_SPAN-1:0] pending_ext;
  logic               accept;

  // Unused select codes read as "not pending", so writes to them are
  // accepted and simply go nowhere.
  always_comb begin
    pending_ext              = '0;
    pending_ext[NUM_CH-1:0]  = pending;
    cfg_ready                = !pending_ext[cfg_ch];
    accept                   = cfg_valid && cfg_ready;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign wr[k] = accept && (cfg_ch == CH_W'(k));

    nco_channel #(
      .ACC_W     (ACC_W),
      .RESET_INC (DEFAULT_INC[k*ACC_W +: ACC_W])
    ) u_ch (
      .clkin    (clkin),
      .reset    (reset),
      .en       (ch_en[k]),
      .wr       (wr[k]),
      .wr_inc   (cfg_inc),
      .wr_phase (cfg_phase),
      .ce       (ce_o[k]),
      .clk      (clk_o[k]),
      .pending  (pending[k]),
      .applied  (applied[k])
    );
  end

  // Lock FSM
  lock_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             cfg_busy;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state <= SETTLING;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cfg_busy = (|applied) || (|pending);
    case (state)
      SETTLING: begin
        // The quiet period restarts from every apply and is held off while
        // anything is still outstanding.
        if (cfg_busy) begin
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = LOCKED;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (cfg_busy) begin
          state_n = SETTLING;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = SETTLING;
        cnt_n   = '0;
      end
    endcase
  end

  assign lock           = (state == LOCKED);
  assign dbg_lock_state = state;

endmodule

// File: tb/tb_multi_nco_clkgen.sv
// Directed bench for multi_nco_clkgen: 3 channels, 32-bit accumulators,
// lock delay 16, channel 0 reset increment 0x8000_0000.
module tb_multi_nco_clkgen;
  import nco_clkgen_pkg::*;

  logic        clkin = 1'b0;
  logic        reset;
  logic [2:0]  ch_en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_inc;
  logic [31:0] cfg_phase;
  logic [2:0]  ce_o;
  logic [2:0]  clk_o;
  logic        lock;
  lock_state_t dbg_lock_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;   // rising edges since the last reset release
  int c1_ref = 0;   // edge on which channel 1 took its 0x4000_0000 increment

  multi_nco_clkgen #(
    .NUM_CH      (3),
    .ACC_W       (32),
    .LOCK_CYCLES (16),
    .DEFAULT_INC ({32'h0000_0000, 32'h0000_0000, 32'h8000_0000})
  ) dut (
    .clkin          (clkin),
    .reset          (reset),
    .ch_en          (ch_en),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_ch         (cfg_ch),
    .cfg_inc        (cfg_inc),
    .cfg_phase      (cfg_phase),
    .ce_o           (ce_o),
    .clk_o          (clk_o),
    .lock           (lock),
    .dbg_lock_state (dbg_lock_state)
  );

  // Clock / reset
  always #5 clkin = ~clkin;

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clkin);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic exp_b;
    reset     = 1'b1;
    ch_en     = 3'b111;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_inc   = '0;
    cfg_phase = '0;
    repeat (3) @(posedge clkin);
    #1;
    checks++; if (ce_o !== 3'b000) begin errors++; $display("FAIL reset_ce got=%b exp=000", ce_o); end
    checks++; if (clk_o !== 3'b000) begin errors++; $display("FAIL reset_clk got=%b exp=000", clk_o); end
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL reset_lock got=%b exp=0", lock); end
    reset = 1'b0;
    cyc   = 0;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp_b = (n % 2 == 0);
      checks++; if (ce_o !== {2'b00, exp_b}) begin errors++; $display("FAIL default_ce n=%0d got=%b exp=00%b", n, ce_o, exp_b); end
      checks++; if (clk_o !== {2'b00, exp_b}) begin errors++; $display("FAIL default_clk n=%0d got=%b exp=00%b", n, clk_o, exp_b); end
      checks++; if (lock !== (n >= 16)) begin errors++; $display("FAIL first_lock n=%0d got=%b exp=%b", n, lock, (n >= 16)); end
    end
  endtask

  task automatic test_ch1_config();
    logic exp_ce, exp_clk;
    cfg_ch    = 2'd1;
    cfg_inc   = 32'h4000_0000;
    cfg_phase = 32'h4000_0000;
    cfg_valid = 1'b1;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ch1_ready_pre got=%b exp=1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ch1_ready_pending got=%b exp=0", cfg_ready); end
    checks++; if (lock !== 1'b1) begin errors++; $display("FAIL ch1_lock_accept got=%b exp=1", lock); end
    tick();
    c1_ref = cyc;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ch1_ready_applied got=%b exp=1", cfg_ready); end
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL ch1_lock_drop got=%b exp=0", lock); end
    checks++; if (clk_o[1] !== 1'b0) begin errors++; $display("FAIL ch1_clk_apply got=%b exp=0", clk_o[1]); end
    for (int n = 1; n <= 16; n++) begin
      tick();
      exp_ce  = (n % 4 == 0);
      exp_clk = (n % 4 >= 2);
      checks++; if (ce_o[1] !== exp_ce) begin errors++; $display("FAIL ch1_ce n=%0d got=%b exp=%b", n, ce_o[1], exp_ce); end
      checks++; if (clk_o[1] !== exp_clk) begin errors++; $display("FAIL ch1_clk n=%0d got=%b exp=%b", n, clk_o[1], exp_clk); end
      checks++; if (lock !== (n >= 16)) begin errors++; $display("FAIL ch1_relock n=%0d got=%b exp=%b", n, lock, (n >= 16)); end
    end
    checks++; if (dbg_lock_state !== LOCKED) begin errors++; $display("FAIL ch1_dbg_state got=%0d exp=%0d", dbg_lock_state, LOCKED); end
  endtask

  task automatic test_ch2_rate();
    int pulses  = 0;
    int last    = 0;
    int gap_err = 0;
    cfg_ch    = 2'd2;
    cfg_inc   = 32'h5555_5556;
    cfg_phase = 32'h0;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();  // zero increment lets the config apply on this edge
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (ce_o[2] === 1'b1) begin
        pulses++;
        if (n - last != 3) gap_err++;
        last = n;
      end
    end
    checks++; if (pulses !== 100) begin errors++; $display("FAIL ch2_pulse_count got=%0d exp=100", pulses); end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL ch2_spacing bad_gaps=%0d exp=0", gap_err); end
  endtask

  task automatic test_back_to_back();
    logic exp_ce;
    // Channel 0 has run at 0x8000_0000 since reset: it carries on even edges.
    if (cyc % 2 == 0) tick();
    cfg_ch    = 2'd0;
    cfg_inc   = 32'h4000_0000;
    cfg_phase = 32'h0;
    cfg_valid = 1'b1;
    tick();  // accept coincides with a carry
    checks++; if (ce_o[0] !== 1'b1) begin errors++; $display("FAIL b2b_ce_accept got=%b exp=1", ce_o[0]); end
    cfg_inc = 32'h1000_0000;  // second write, must be refused
    #1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_0 got=%b exp=0", cfg_ready); end
    tick();
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_1 got=%b exp=0", cfg_ready); end
    checks++; if (ce_o[0] !== 1'b0) begin errors++; $display("FAIL b2b_ce n=1 got=%b exp=0", ce_o[0]); end
    cfg_valid = 1'b0;
    for (int n = 2; n <= 14; n++) begin
      tick();
      exp_ce = (n == 2) || (n >= 6 && (n - 2) % 4 == 0);
      checks++; if (ce_o[0] !== exp_ce) begin errors++; $display("FAIL b2b_ce n=%0d got=%b exp=%b", n, ce_o[0], exp_ce); end
    end
  endtask

  task automatic test_disable_pending();
    logic exp_b;
    int guard = 0;
    // Align to a channel 1 carry edge so the next edge cannot apply.
    while (((cyc - c1_ref) % 4 != 0) && guard < 8) begin
      tick();
      guard++;
    end
    cfg_ch    = 2'd1;
    cfg_inc   = 32'h8000_0000;
    cfg_phase = 32'h0;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL dis_ready_pending got=%b exp=0", cfg_ready); end
    ch_en[1] = 1'b0;
    tick();
    checks++; if (ce_o[1] !== 1'b0) begin errors++; $display("FAIL dis_ce got=%b exp=0", ce_o[1]); end
    checks++; if (clk_o[1] !== 1'b0) begin errors++; $display("FAIL dis_clk got=%b exp=0", clk_o[1]); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL dis_ready_cleared got=%b exp=1", cfg_ready); end
    ch_en[1] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      exp_b = (n % 2 == 0);
      checks++; if (ce_o[1] !== exp_b) begin errors++; $display("FAIL reen_ce n=%0d got=%b exp=%b", n, ce_o[1], exp_b); end
      checks++; if (clk_o[1] !== exp_b) begin errors++; $display("FAIL reen_clk n=%0d got=%b exp=%b", n, clk_o[1], exp_b); end
    end
  endtask

  task automatic test_reset_midrun();
    logic exp_b;
    repeat (20) tick();
    checks++; if (lock !== 1'b1) begin errors++; $display("FAIL mid_lock_pre got=%b exp=1", lock); end
    // Out-of-range channel: always ready, write dropped.
    cfg_ch    = 2'd3;
    cfg_inc   = 32'h0000_FFFF;
    cfg_phase = 32'h0;
    cfg_valid = 1'b1;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL oor_ready got=%b exp=1", cfg_ready); end
    tick();
    tick();
    cfg_valid = 1'b0;
    checks++; if (lock !== 1'b1) begin errors++; $display("FAIL oor_lock got=%b exp=1", lock); end
    for (int c = 0; c < 3; c++) begin
      cfg_ch = 2'(c);
      #1;
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL oor_ready_ch%0d got=%b exp=1", c, cfg_ready); end
    end
    // Leave a config pending on channel 2, then reset.
    cfg_ch    = 2'd2;
    cfg_inc   = 32'h1000_0000;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_pending got=%b exp=0", cfg_ready); end
    checks++; if (lock !== 1'b1) begin errors++; $display("FAIL mid_lock_accept got=%b exp=1", lock); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ce_o !== 3'b000) begin errors++; $display("FAIL mid_reset_ce got=%b exp=000", ce_o); end
    checks++; if (clk_o !== 3'b000) begin errors++; $display("FAIL mid_reset_clk got=%b exp=000", clk_o); end
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL mid_reset_lock got=%b exp=0", lock); end
    repeat (2) @(posedge clkin);
    #1;
    reset = 1'b0;
    cyc   = 0;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after got=%b exp=1", cfg_ready); end
    for (int n = 1; n <= 16; n++) begin
      tick();
      exp_b = (n % 2 == 0);
      checks++; if (ce_o !== {2'b00, exp_b}) begin errors++; $display("FAIL post_ce n=%0d got=%b exp=00%b", n, ce_o, exp_b); end
      checks++; if (clk_o !== {2'b00, exp_b}) begin errors++; $display("FAIL post_clk n=%0d got=%b exp=00%b", n, clk_o, exp_b); end
      checks++; if (lock !== (n >= 16)) begin errors++; $display("FAIL post_lock n=%0d got=%b exp=%b", n, lock, (n >= 16)); end
    end
  endtask

  initial begin
    test_reset();
    test_ch1_config();
    test_ch2_rate();
    test_back_to_back();
    test_disable_pending();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_nco_clkgen.md
Name: multi_nco_clkgen

Overview:
- Parametrised, runtime-programmable clock-enable generator. It derives NUM_CH independent audio/peripheral timing channels from the single PLL output clock (72 MHz from 27 MHz ×8/3).
- Each channel is a phase-accumulator NCO that produces a one-cycle enable pulse and a phase-offset square wave.
- Output updates are glitch-free: new settings take effect only at a wrap boundary.
- A LOCK-style status output marks when all channels have settled.
- Sits between the PLL wrapper and the I2S/ethernet audio datapath. It replaces fixed divider outputs with software-tunable rates, e.g. MCLK/BCLK/LRCK for 44.1k/48k families.

Parameters:
- NUM_CH, 3, number of NCO channels (1..8).
- ACC_W, 32, accumulator/increment width in bits (16..32).
- LOCK_CYCLES, 16, clkin cycles after reset or last applied config before lock asserts (≥1).
- DEFAULT_INC, {NUM_CH{ACC_W'h0}}, flattened per-channel reset increment; channel k is bits [k*ACC_W +: ACC_W].

Ports:
- clkin, input, 1, PLL output clock; all logic runs on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- ch_en, input, NUM_CH, per-channel run enable.
- cfg_valid, input, 1, config write request.
- cfg_ready, output, 1, config write can be accepted this cycle.
- cfg_ch, input, CH_W = max(1, clog2(NUM_CH)), target channel.
- cfg_inc, input, ACC_W, new phase increment.
- cfg_phase, input, ACC_W, new phase offset for clk_o.
- ce_o, output, NUM_CH, one-cycle enable pulse, one per accumulator wrap.
- clk_o, output, NUM_CH, registered square wave, MSB of (acc + phase).
- lock, output, 1, all configuration applied and LOCK_CYCLES elapsed.

Behaviour:
- Reset (async assert, sync release):
  - acc = 0, inc = DEFAULT_INC, phase = 0, pending = 0.
  - ce_o = 0, clk_o = 0, lock = 0, lock counter = 0.
  - cfg_ready = 1 after reset release.
- Channel running (ch_en[k] = 1): acc_k <= acc_k + inc_k, modulo 2^ACC_W.
  - The carry out of that add is registered into ce_o[k] next cycle (latency 1).
  - clk_o[k] <= MSB(acc_k + phase_k), evaluated on the pre-update acc.
- Channel disabled (ch_en[k] = 0): acc_k <= 0, ce_o[k] <= 0, clk_o[k] <= 0.
  - Any pending config for k is applied immediately.
- inc_k = 0: acc holds, no ce pulses, clk_o fixed at MSB(acc + phase). This is legal.
- Config handshake: a write is accepted when cfg_valid & cfg_ready.
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
  - If cfg_ch ≥ NUM_CH, cfg_ready = 1 and the write is accepted and discarded.
  - An accepted write loads shadow_inc/shadow_phase for the channel and sets pending[cfg_ch].
- Apply rule: pending channel k loads inc_k/phase_k and clears pending in any of these cycles:
  - the cycle its accumulator add carries out;
  - any cycle ch_en[k] = 0;
  - any cycle inc_k = 0.
  - The newly loaded inc is used from the following add onward.
- Simultaneous accept and carry on the same channel: the shadow is written, and the apply waits for the next carry. The current wrap uses the old values.
- Lock control is a two-state FSM:
  - SETTLING: counter increments each cycle. When counter == LOCK_CYCLES-1 and no pending bits are set → LOCKED, lock = 1.
  - LOCKED: if any config is applied, or any pending bit is set → SETTLING with the counter cleared, lock = 0 on the next cycle.
  - Changes on ch_en do not affect lock.
- reset asserted mid-operation: all state clears immediately (async). Any in-flight config is lost.

Decomposition:
- Package nco_clkgen_pkg holds:
  - ACC_W and LOCK_CYCLES defaults;
  - the CH_W computation function;
  - the lock FSM state typedef (SETTLING/LOCKED).
- Sub-module nco_channel, instantiated NUM_CH times via generate, contains:
  - accumulator, shadow registers, pending flag, apply logic;
  - registered ce/clk outputs.
- The top level holds the cfg decode, the cfg_ready mux and the lock FSM.

Test Plan:
- Reset with DEFAULT_INC ch0 = 0x8000_0000, ch_en = 1 → ce_o[0] pulses every 2nd cycle starting cycle 2, clk_o[0] toggles every cycle; lock rises exactly 16 cycles after reset release.
- Write ch1 inc = 0x4000_0000, phase = 0x4000_0000 with ch_en[1] = 1 → cfg_ready[ch1] drops for ≤4 cycles; after the next carry, ce_o[1] has period 4 and clk_o[1] reads 1,1,0,0 shifted by 1 cycle vs phase = 0; lock falls, then re-rises 16 cycles after the apply.
- ch2 inc = 0x5555_5556 for 300 cycles → exactly 100 ce pulses, each spaced 3 cycles apart.
- Write ch0 in the same cycle as its carry → the old period is kept for one more wrap, the new period starts after the next carry; a second write attempted meanwhile sees cfg_ready = 0 and is not accepted.
- Deassert ch_en[1] with pending config → next cycle acc = 0, ce/clk = 0, pending cleared, cfg_ready = 1; re-enable → output starts at the new rate.
- Assert reset mid-run with pending config → outputs 0 and lock = 0 the same cycle; after release, channels run at DEFAULT_INC with pending discarded.
